// File: rtl/obi2hci_bridge.sv
// OBI manager to HCI initiator bridge with in-order ID tracking and an
// address window whose misses are answered locally with an OBI error.
module obi2hci_bridge #(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter int unsigned          IdWidth        = 1,
    parameter int unsigned          MaxOutstanding = 4,
    parameter logic [AddrWidth-1:0] BaseAddr       = '0,
    parameter logic [AddrWidth-1:0] AddrSize       = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  obi_req_i,
    input  logic [AddrWidth-1:0]                  obi_addr_i,
    input  logic                                  obi_we_i,
    input  logic [DataWidth/8-1:0]                obi_be_i,
    input  logic [DataWidth-1:0]                  obi_wdata_i,
    input  logic [IdWidth-1:0]                    obi_aid_i,
    output logic                                  obi_gnt_o,
    output logic                                  obi_rvalid_o,
    output logic [DataWidth-1:0]                  obi_rdata_o,
    output logic [IdWidth-1:0]                    obi_rid_o,
    output logic                                  obi_err_o,
    output logic                                  obi_exokay_o,
    output logic                                  hci_req_o,
    output logic [AddrWidth-1:0]                  hci_add_o,
    output logic                                  hci_wen_o,
    output logic [DataWidth-1:0]                  hci_data_o,
    output logic [DataWidth/8-1:0]                hci_be_o,
    output logic [15:0]                           hci_boffs_o,
    output logic                                  hci_lrdy_o,
    output logic                                  hci_user_o,
    input  logic                                  hci_gnt_i,
    input  logic                                  hci_r_valid_i,
    input  logic [DataWidth-1:0]                  hci_r_data_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  unexpected_rsp_o
);

    localparam int unsigned    CntW    = $clog2(MaxOutstanding + 1);
    localparam int unsigned    PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] Depth   = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [IdWidth-1:0]   aid_q  [MaxOutstanding];
    logic                 lerr_q [MaxOutstanding];
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 rdy_q;
    logic                 unexp_q, unexp_d;

    logic                 en, in_win, full, head_vld, head_lerr;
    logic                 hci_req, lerr_gnt, push, hci_rsp, lerr_rsp, pop;
    logic [AddrWidth-1:0] offset;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // rdy_q holds everything quiet for the first cycle after reset release
    assign en        = rst_ni & rdy_q;
    assign offset    = obi_addr_i - BaseAddr;
    assign in_win    = (AddrSize == '0) || (offset < AddrSize);
    assign full      = (cnt_q == Depth);
    assign head_vld  = (cnt_q != '0);
    assign head_lerr = head_vld & lerr_q[rptr_q];

    // A local error entry sits alone in the FIFO, so it never meets an HCI response
    assign hci_req  = en & obi_req_i & in_win & ~full & ~head_lerr;
    assign lerr_gnt = en & obi_req_i & ~in_win & (cnt_q == '0);
    assign push     = (hci_req & hci_gnt_i) | lerr_gnt;
    assign hci_rsp  = en & hci_r_valid_i & head_vld & ~head_lerr;
    assign lerr_rsp = en & head_lerr;
    assign pop      = hci_rsp | lerr_rsp;
    assign unexp_d  = hci_r_valid_i & ~(head_vld & ~head_lerr);

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            unexp_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            unexp_q <= unexp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            aid_q[wptr_q]  <= obi_aid_i;
            lerr_q[wptr_q] <= ~in_win;
        end
    end

    assign obi_gnt_o        = push;
    assign obi_rvalid_o     = pop;
    assign obi_rdata_o      = hci_rsp ? hci_r_data_i : '0;
    assign obi_rid_o        = pop ? aid_q[rptr_q] : '0;
    assign obi_err_o        = lerr_rsp;
    assign obi_exokay_o     = hci_rsp;

    assign hci_req_o        = hci_req;
    assign hci_add_o        = obi_addr_i;
    assign hci_wen_o        = ~obi_we_i;
    assign hci_data_o       = obi_wdata_i;
    assign hci_be_o         = obi_be_i;
    assign hci_boffs_o      = '0;
    assign hci_lrdy_o       = 1'b1;
    assign hci_user_o       = 1'b0;

    assign outstanding_o    = cnt_q;
    assign unexpected_rsp_o = unexp_q;

endmodule

// File: tb/tb_obi2hci_bridge.sv
// Bench for obi2hci_bridge: directed steps plus random traffic against a
// queue-based model of the tracking behaviour.
module tb_obi2hci_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          obi_req_i;
    logic [AW-1:0] obi_addr_i;
    logic          obi_we_i;
    logic [DW/8-1:0] obi_be_i;
    logic [DW-1:0] obi_wdata_i;
    logic [IW-1:0] obi_aid_i;
    logic          obi_gnt_o;
    logic          obi_rvalid_o;
    logic [DW-1:0] obi_rdata_o;
    logic [IW-1:0] obi_rid_o;
    logic          obi_err_o;
    logic          obi_exokay_o;
    logic          hci_req_o;
    logic [AW-1:0] hci_add_o;
    logic          hci_wen_o;
    logic [DW-1:0] hci_data_o;
    logic [DW/8-1:0] hci_be_o;
    logic [15:0]   hci_boffs_o;
    logic          hci_lrdy_o;
    logic          hci_user_o;
    logic          hci_gnt_i;
    logic          hci_r_valid_i;
    logic [DW-1:0] hci_r_data_i;
    logic [CW-1:0] outstanding_o;
    logic          unexpected_rsp_o;

    obi2hci_bridge #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO),
        .BaseAddr(32'h0000_1000), .AddrSize(32'h0000_0100)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .obi_req_i(obi_req_i), .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i),
        .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i), .obi_aid_i(obi_aid_i),
        .obi_gnt_o(obi_gnt_o), .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o),
        .obi_rid_o(obi_rid_o), .obi_err_o(obi_err_o), .obi_exokay_o(obi_exokay_o),
        .hci_req_o(hci_req_o), .hci_add_o(hci_add_o), .hci_wen_o(hci_wen_o),
        .hci_data_o(hci_data_o), .hci_be_o(hci_be_o), .hci_boffs_o(hci_boffs_o),
        .hci_lrdy_o(hci_lrdy_o), .hci_user_o(hci_user_o), .hci_gnt_i(hci_gnt_i),
        .hci_r_valid_i(hci_r_valid_i), .hci_r_data_i(hci_r_data_i),
        .outstanding_o(outstanding_o), .unexpected_rsp_o(unexpected_rsp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] aid;
        bit            lerr;
    } ent_t;

    ent_t mq[$];
    bit   m_ready;
    bit   m_unexp;
    int   tests;
    int   fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive, predict from the queue model, compare, advance.
    task automatic step(input bit req, input logic [31:0] addr, input bit we,
                        input logic [IW-1:0] aid, input bit gi, input bit rv,
                        input logic [31:0] rd);
        bit            en, hv, hl, iw, e_hreq, e_gnt, e_rv, nxt_unexp;
        logic [31:0]   off, wd;
        logic [3:0]    be;
        ent_t          e;
        wd = $urandom();
        be = 4'($urandom());
        obi_req_i = req; obi_addr_i = addr; obi_we_i = we; obi_aid_i = aid;
        obi_wdata_i = wd; obi_be_i = be;
        hci_gnt_i = gi; hci_r_valid_i = rv; hci_r_data_i = rd;
        #1;
        en     = m_ready;
        hv     = (mq.size() != 0);
        hl     = hv && mq[0].lerr;
        off    = addr - 32'h0000_1000;
        iw     = (off < 32'h0000_0100);
        e_hreq = en && req && iw && (mq.size() < MO) && !hl;
        e_gnt  = iw ? (e_hreq && gi) : (en && req && (mq.size() == 0));
        e_rv   = en && hv && (hl || rv);
        check("outstanding", 64'(outstanding_o), 64'(mq.size()));
        check("unexpected", 64'(unexpected_rsp_o), 64'(m_unexp));
        check("gnt", 64'(obi_gnt_o), 64'(e_gnt));
        check("hci_req", 64'(hci_req_o), 64'(e_hreq));
        check("rvalid", 64'(obi_rvalid_o), 64'(e_rv));
        check("rdata", 64'(obi_rdata_o), (e_rv && !hl) ? 64'(rd) : 64'd0);
        check("rid", 64'(obi_rid_o), e_rv ? 64'(mq[0].aid) : 64'd0);
        check("err", 64'(obi_err_o), 64'(e_rv && hl));
        check("exokay", 64'(obi_exokay_o), 64'(e_rv && !hl));
        if (e_hreq) begin
            check("hci_add", 64'(hci_add_o), 64'(addr));
            check("hci_wen", 64'(hci_wen_o), 64'(!we));
            check("hci_data", 64'(hci_data_o), 64'(wd));
            check("hci_be", 64'(hci_be_o), 64'(be));
        end
        nxt_unexp = rv && !(hv && !hl);
        if (e_rv) void'(mq.pop_front());
        if (e_gnt) begin
            e.aid = aid; e.lerr = !iw;
            mq.push_back(e);
        end
        @(posedge clk_i); #1;
        m_unexp = nxt_unexp;
        m_ready = 1'b1;
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0; obi_req_i = 1'b1; obi_addr_i = 32'h0000_1010; obi_we_i = 1'b0;
        obi_aid_i = '0; obi_be_i = '1; obi_wdata_i = '0;
        hci_gnt_i = 1'b1; hci_r_valid_i = 1'b0; hci_r_data_i = '0;
        repeat (n) begin
            #1;
            check("rst_gnt", 64'(obi_gnt_o), 64'd0);
            check("rst_hci_req", 64'(hci_req_o), 64'd0);
            check("rst_rvalid", 64'(obi_rvalid_o), 64'd0);
            @(posedge clk_i); #1;
        end
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_unexpected", 64'(unexpected_rsp_o), 64'd0);
        rst_ni = 1'b1; obi_req_i = 1'b0; hci_gnt_i = 1'b0;
        mq.delete();
        m_ready = 1'b0;
        m_unexp = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        do_reset(2);
        check("boffs", 64'(hci_boffs_o), 64'd0);
        check("lrdy", 64'(hci_lrdy_o), 64'd1);
        check("user", 64'(hci_user_o), 64'd0);
        // first cycle after reset: request held in-window with grant available
        step(1, 32'h0000_1000, 0, 4'd9, 1, 0, 0);

        // fill to MaxOutstanding, fifth stalls, then one response frees a slot
        for (int i = 0; i < 5; i++) step(1, 32'h0000_1000 + 32'(i * 4), 0, 4'(i), 1, 0, 0);
        step(1, 32'h0000_1010, 0, 4'd4, 1, 1, 32'hA5A5_0000);
        step(1, 32'h0000_1010, 0, 4'd4, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, $urandom());

        // out-of-window single, window edges, back-to-back out-of-window
        step(1, 32'h0000_1100, 0, 4'd7, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h0000_10FF, 1, 4'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        step(1, 32'h0000_0FFF, 0, 4'd2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h0000_2000, 0, 4'd5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // out-of-window waits for drain; in-window waits for the error response
        step(1, 32'h0000_1020, 0, 4'd1, 1, 0, 0);
        step(1, 32'h0000_1024, 0, 4'd2, 1, 0, 0);
        step(1, 32'h0000_3000, 0, 4'd9, 1, 1, 32'h0000_0011);
        step(1, 32'h0000_3000, 0, 4'd9, 1, 1, 32'h0000_0022);
        step(1, 32'h0000_3000, 0, 4'd9, 1, 0, 0);
        step(1, 32'h0000_1030, 0, 4'd3, 1, 0, 0);
        step(1, 32'h0000_1030, 0, 4'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hCAFE_0003);

        // response with nothing outstanding
        step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // steady push+pop at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1, 32'h0000_1040, 0, 4'(i), 1, 0, 0);
        for (int i = 3; i < 11; i++) step(1, 32'h0000_1040, 0, 4'(i), 1, 1, $urandom());
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, $urandom());

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'h0000_4000 + 32'($urandom_range(0, 255))
                                            : 32'h0000_1000 + 32'($urandom_range(0, 255));
            step(bit'($urandom_range(0, 1)), a, bit'($urandom_range(0, 1)),
                 4'($urandom()), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), $urandom());
        end

        // reset with transactions in flight; late responses are dropped and flagged
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        while (mq.size() != 0) step(0, 0, 0, 0, 0, 1, $urandom());
        step(1, 32'h0000_1000, 0, 4'd1, 1, 0, 0);
        step(1, 32'h0000_1004, 0, 4'd2, 1, 0, 0);
        do_reset(1);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0001);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0002);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi2hci_bridge.md
# obi2hci_bridge

Parametrised OBI-to-HCI bridge for the tile's core-to-L1 path. It extends the stateless request/response field mapping with in-order tracking of up to `MaxOutstanding` transactions, so `rid` returns the original `aid`. It also enforces a configurable address window, answering out-of-window requests locally with an OBI error response instead of forwarding them to HCI. It sits between one OBI manager port and one HCI initiator port.

## Interface
- `AddrWidth`, 32, address width, both sides
- `DataWidth`, 32, data width; `be` is `DataWidth/8`
- `IdWidth`, 1, OBI `aid`/`rid` width
- `MaxOutstanding`, 4, tracking FIFO depth; must be at least 1; need not be a power of two
- `BaseAddr`, 0, window base
- `AddrSize`, 0, window size in bytes; 0 means the whole address space is in-window
- `clk_i` in 1: clock
- `rst_ni` in 1: reset; one clock, synchronous, active-low
- `obi_req_i` in 1, `obi_addr_i` in AddrWidth, `obi_we_i` in 1, `obi_be_i` in DataWidth/8, `obi_wdata_i` in DataWidth, `obi_aid_i` in IdWidth: OBI A channel
- `obi_gnt_o` out 1: OBI grant
- `obi_rvalid_o` out 1, `obi_rdata_o` out DataWidth, `obi_rid_o` out IdWidth, `obi_err_o` out 1, `obi_exokay_o` out 1: OBI R channel; no `rready`, so responses are always accepted
- `hci_req_o` out 1, `hci_add_o` out AddrWidth, `hci_wen_o` out 1 (1 = read), `hci_data_o` out DataWidth, `hci_be_o` out DataWidth/8: HCI request
- `hci_boffs_o` out 16: tied 0
- `hci_lrdy_o` out 1: tied 1
- `hci_user_o` out 1: tied 0
- `hci_gnt_i` in 1, `hci_r_valid_i` in 1, `hci_r_data_i` in DataWidth: HCI grant and response
- `outstanding_o` out $clog2(MaxOutstanding+1): current tracking FIFO occupancy
- `unexpected_rsp_o` out 1: single-cycle pulse when `hci_r_valid_i` arrives with no HCI entry at the FIFO head

## Operation
- Window check: `in_win = (AddrSize == 0) || ((obi_addr_i - BaseAddr) < AddrSize)`. The subtraction is unsigned modulo 2^AddrWidth.
- Tracking FIFO: `MaxOutstanding` entries of `{aid, lerr}`. `full` means count == MaxOutstanding.
- `err_pend`: FIFO holds an `lerr` entry.
- In-window path:
  - `hci_req_o = obi_req_i & in_win & ~full & ~err_pend`.
  - Request fields pass straight through: `hci_add_o = addr`, `hci_wen_o = ~we`, `hci_data_o = wdata`, `hci_be_o = be`.
  - `obi_gnt_o = hci_req_o & hci_gnt_i`.
  - On grant, push `{aid, 0}`.
- Out-of-window path:
  - `obi_gnt_o = obi_req_i & ~in_win & (count == 0)`. The FIFO must be drained before the local error is granted.
  - `hci_req_o` stays 0.
  - On grant, push `{aid, 1}`.
- HCI returns exactly one `r_valid` per granted request, reads and writes alike, in grant order.
- HCI response handling, when the head is `lerr = 0` and `hci_r_valid_i = 1`:
  - `obi_rvalid_o = 1`, `obi_rdata_o = hci_r_data_i`, `obi_rid_o = head.aid`, `obi_err_o = 0`, `obi_exokay_o = 1`.
  - Pop the head the same cycle.
- Local error handling, when the head is `lerr = 1`:
  - The cycle after it becomes head: `obi_rvalid_o = 1`, `obi_rdata_o = 0`, `obi_rid_o = head.aid`, `obi_err_o = 1`, `obi_exokay_o = 0`.
  - Pop.
  - Registered, so there are no combinational paths into the R channel from the A channel.
- Ordering guarantee: an `lerr` entry is only ever alone in the FIFO, so it never collides with an HCI response.
- Unexpected response: `hci_r_valid_i` with the FIFO empty or the head `lerr = 1` is dropped, and `unexpected_rsp_o` pulses.
- When `obi_rvalid_o = 0`, `obi_rdata_o`, `obi_rid_o`, `obi_err_o` and `obi_exokay_o` are driven 0.

## Timing
- Reset (`rst_ni` = 0 at a rising edge):
  - FIFO empty, `outstanding_o = 0`, `unexpected_rsp_o = 0`, local-error response register clear.
  - `obi_gnt_o`, `obi_rvalid_o` and `hci_req_o` are 0 while in reset and the first cycle after.
- Reset mid-operation: all tracked transactions are discarded. Any HCI responses arriving after reset are dropped and flagged by `unexpected_rsp_o`.
- In-window latency:
  - Grant is combinational with `hci_gnt_i`.
  - Response is combinational with `hci_r_valid_i`; the bridge adds 0 cycles.
- Local error latency: grant in cycle t, `obi_rvalid_o` with `err` in cycle t+1.
  - Back-to-back out-of-window requests: grant t, response t+1, next grant t+2, since the FIFO is empty only after the pop.
- Full FIFO:
  - No grant while count == MaxOutstanding, even if a pop occurs that cycle. The grant does not depend on `r_valid`.
  - A new grant is possible from the cycle after the pop.
- Simultaneous push and pop (not full): count unchanged; pointers wrap modulo MaxOutstanding.
- `outstanding_o` is registered and reflects pushes and pops from the previous edge.

## Test plan
- Reset, then drive `obi_req_i=1` in-window with `hci_gnt_i=1` held in reset -> `obi_gnt_o=0` and `hci_req_o=0` during reset; `outstanding_o=0` afterwards.
- MaxOutstanding=4: issue 5 reads with `aid` 0..4, `hci_gnt_i=1`, no `r_valid` -> 4 grants, 5th stalled, `outstanding_o=4`.
  - Then one `r_valid` with data 0xA5A5_0000 -> `rid=0`, data forwarded, 5th granted the following cycle.
- BaseAddr=0x1000, AddrSize=0x100: request to 0x1100 with empty FIFO -> granted, `hci_req_o=0`, next cycle `rvalid=1`, `err=1`, `exokay=0`, `rdata=0`, `rid` = its `aid`.
- Out-of-window request while 2 in-window are outstanding -> no grant until both responses return and count = 0, then grant.
  - An in-window request following the error -> stalled until the error response cycle passes.
- `hci_r_valid_i=1` with the FIFO empty -> `obi_rvalid_o=0`, `unexpected_rsp_o` pulses one cycle.
- Sustained push and pop at count 3, for 8 cycles across pointer wrap with `aid` incrementing -> `rid` sequence matches issue order and `outstanding_o` stays 3.
